score_tracker: RTL and testbench

Sits directly downstream of the game controller on the same `clk_100ms` tick. It follows the controller's binary `score` and keeps a 4-digit packed-BCD copy for the seven-segment driver, updated incrementally each tick. It falls back to a sequential double-dabble resync when the score jumps unexpectedly. It also keeps a per-mode best score and drives a new-record blink flag after game over.

---
 rtl/score_pkg.sv | 30 +++
 rtl/score_tracker_if.sv | 27 ++
 rtl/score_tracker_bcd_add3.sv | 38 +++
 rtl/score_tracker.sv | 202 ++++++++++++++++++++
 tb/tb_score_tracker.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the score tracker: FSM states, saturation
// limits and the double-dabble digit-adjust helper.
package score_pkg;

    typedef enum logic [1:0] {
        TRACK  = 2'd0,
        RESYNC = 2'd1,
        OVER   = 2'd2
    } state_e;

    localparam int unsigned MAX_BIN    = 9999;
    localparam logic [15:0] MAX_BCD    = 16'h9999;
    localparam int unsigned BLINK_HALF = 5;
    localparam logic [3:0]  DD_LAST    = 4'd15;

    // Add 3 to every BCD digit that is 5 or more (pre-shift correction).
    function automatic logic [15:0] dd_adjust(input logic [15:0] bcd);
        logic [15:0] r;
        r = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end else begin
                r[i*4 +: 4] = bcd[i*4 +: 4];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/score_tracker_if.sv
// Controller-to-tracker bundle: score/status inputs and display/record outputs.
interface score_tracker_if;

    logic [15:0] score;
    logic [1:0]  status;
    logic        game_over;
    logic        clr_best;

    logic [15:0] cur_bcd;
    logic [15:0] best_bcd;
    logic [13:0] best_bin;
    logic        new_record;
    logic        blink;
    logic        busy;
    logic        overflow;

    modport master (
        output score, status, game_over, clr_best,
        input  cur_bcd, best_bcd, best_bin, new_record, blink, busy, overflow
    );

    modport slave (
        input  score, status, game_over, clr_best,
        output cur_bcd, best_bcd, best_bin, new_record, blink, busy, overflow
    );

endinterface

// File: rtl/score_tracker_bcd_add3.sv
// Combinational 4-digit packed-BCD plus 0..3 adder; saturates to 9999 on
// carry out of the top digit and flags it.
module bcd_add3
    import score_pkg::*;
(
    input  logic [15:0] bcd_in,
    input  logic [1:0]  inc,
    output logic [15:0] bcd_out,
    output logic        sat
);

    logic [15:0] sum;
    logic [4:0]  digit;
    logic        carry;

    always_comb begin
        sum   = '0;
        digit = '0;
        carry = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i == 0) begin
                digit = {1'b0, bcd_in[i*4 +: 4]} + {3'b000, inc};
            end else begin
                digit = {1'b0, bcd_in[i*4 +: 4]} + {4'b0000, carry};
            end
            if (digit > 5'd9) begin
                sum[i*4 +: 4] = 4'(digit - 5'd10);
                carry         = 1'b1;
            end else begin
                sum[i*4 +: 4] = digit[3:0];
                carry         = 1'b0;
            end
        end
        sat     = carry;
        bcd_out = carry ? MAX_BCD : sum;
    end

endmodule

// File: rtl/score_tracker.sv
// Tracks the controller score as packed BCD (incremental add or double-dabble
// resync), keeps per-mode best scores and blinks on a new record.
module score_tracker
    import score_pkg::*;
#(
    parameter int unsigned MAX_BIN    = score_pkg::MAX_BIN,
    parameter int unsigned BLINK_HALF = score_pkg::BLINK_HALF
) (
    input  logic            clk_100ms,
    input  logic            rst,
    score_tracker_if.slave  trk
);

    localparam logic [15:0] CAP        = 16'(MAX_BIN);
    localparam logic [13:0] CAP14      = 14'(MAX_BIN);
    localparam logic [7:0]  BLINK_LAST = 8'(BLINK_HALF - 1);

    state_e      state_q, state_d;
    logic [15:0] cur_bcd_q, cur_bcd_d;
    logic [15:0] prev_q, prev_d;
    logic [15:0] latch_q, latch_d;
    logic [15:0] dd_bin_q, dd_bin_d;
    logic [15:0] dd_bcd_q, dd_bcd_d;
    logic [3:0]  iter_q, iter_d;
    logic        busy_q, busy_d;
    logic        overflow_q, overflow_d;
    logic        new_record_q, new_record_d;
    logic        blink_q, blink_d;
    logic        scored_q, scored_d;
    logic [7:0]  blink_cnt_q, blink_cnt_d;

    // Power-up value only; rst deliberately leaves the records alone.
    logic [1:0][13:0] best_bin_q = '0;
    logic [1:0][15:0] best_bcd_q = '0;
    logic [1:0][13:0] best_bin_d;
    logic [1:0][15:0] best_bcd_d;

    logic [15:0] delta;
    logic        small_step;
    logic        jump;
    logic [15:0] add_bcd;
    logic        add_sat;
    logic [31:0] dd_shift;
    logic        dd_last;
    logic [13:0] prev_capped;
    logic        mode;

    assign delta       = trk.score - prev_q;
    assign small_step  = (delta != 16'd0) && (delta <= 16'd3);
    assign jump        = delta > 16'd3;
    assign dd_shift    = {dd_adjust(dd_bcd_q), dd_bin_q} << 1;
    assign dd_last     = iter_q == DD_LAST;
    assign prev_capped = (prev_q > CAP) ? CAP14 : prev_q[13:0];
    assign mode        = trk.status[1];

    bcd_add3 u_add (
        .bcd_in  (cur_bcd_q),
        .inc     (delta[1:0]),
        .bcd_out (add_bcd),
        .sat     (add_sat)
    );

    always_ff @(posedge clk_100ms or negedge rst) begin
        if (!rst) begin
            state_q      <= TRACK;
            cur_bcd_q    <= '0;
            prev_q       <= '0;
            latch_q      <= '0;
            dd_bin_q     <= '0;
            dd_bcd_q     <= '0;
            iter_q       <= '0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            new_record_q <= 1'b0;
            blink_q      <= 1'b0;
            scored_q     <= 1'b0;
            blink_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cur_bcd_q    <= cur_bcd_d;
            prev_q       <= prev_d;
            latch_q      <= latch_d;
            dd_bin_q     <= dd_bin_d;
            dd_bcd_q     <= dd_bcd_d;
            iter_q       <= iter_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
            new_record_q <= new_record_d;
            blink_q      <= blink_d;
            scored_q     <= scored_d;
            blink_cnt_q  <= blink_cnt_d;
        end
    end

    always_ff @(posedge clk_100ms) begin
        best_bin_q <= best_bin_d;
        best_bcd_q <= best_bcd_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TRACK: begin
                if (jump) begin
                    state_d = RESYNC;
                end else if (trk.game_over) begin
                    state_d = OVER;
                end
            end
            RESYNC: begin
                if (dd_last) begin
                    state_d = trk.game_over ? OVER : TRACK;
                end
            end
            OVER:    state_d = OVER;
            default: state_d = TRACK;
        endcase
    end

    always_comb begin
        cur_bcd_d    = cur_bcd_q;
        prev_d       = prev_q;
        latch_d      = latch_q;
        dd_bin_d     = dd_bin_q;
        dd_bcd_d     = dd_bcd_q;
        iter_d       = iter_q;
        busy_d       = busy_q;
        overflow_d   = overflow_q;
        new_record_d = new_record_q;
        blink_d      = blink_q;
        scored_d     = scored_q;
        blink_cnt_d  = blink_cnt_q;
        best_bin_d   = best_bin_q;
        best_bcd_d   = best_bcd_q;

        unique case (state_q)
            TRACK: begin
                if (small_step) begin
                    cur_bcd_d = add_bcd;
                    prev_d    = trk.score;
                    if (add_sat || (trk.score > CAP)) begin
                        overflow_d = 1'b1;
                    end
                end else if (jump) begin
                    latch_d  = trk.score;
                    dd_bin_d = (trk.score > CAP) ? CAP : trk.score;
                    dd_bcd_d = '0;
                    iter_d   = '0;
                    busy_d   = 1'b1;
                    if (trk.score > CAP) begin
                        overflow_d = 1'b1;
                    end
                end
            end
            RESYNC: begin
                dd_bcd_d = dd_shift[31:16];
                dd_bin_d = dd_shift[15:0];
                iter_d   = iter_q + 4'd1;
                if (dd_last) begin
                    cur_bcd_d = dd_shift[31:16];
                    prev_d    = latch_q;
                    busy_d    = 1'b0;
                end
            end
            OVER: begin
                // cur_bcd_q always holds the BCD of min(prev, MAX_BIN), so it
                // doubles as the BCD form of the new record.
                if (!scored_q) begin
                    scored_d = 1'b1;
                    if (prev_capped > best_bin_q[mode]) begin
                        best_bin_d[mode] = prev_capped;
                        best_bcd_d[mode] = cur_bcd_q;
                        new_record_d     = 1'b1;
                    end
                end
                if (new_record_q) begin
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        blink_d     = ~blink_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 8'd1;
                    end
                end
            end
            default: ;
        endcase

        if (trk.clr_best) begin
            best_bin_d = '0;
            best_bcd_d = '0;
        end
    end

    assign trk.cur_bcd    = cur_bcd_q;
    assign trk.best_bcd   = best_bcd_q[mode];
    assign trk.best_bin   = best_bin_q[mode];
    assign trk.new_record = new_record_q;
    assign trk.blink      = blink_q;
    assign trk.busy       = busy_q;
    assign trk.overflow   = overflow_q;

endmodule

// File: tb/tb_score_tracker.sv
// Directed self-checking bench for score_tracker: delta path, resync, records,
// blink, clear and saturation.
module tb_score_tracker;

    logic clk_100ms;
    logic rst;
    int unsigned n_checks;
    int unsigned n_errors;

    score_tracker_if trk ();

    score_tracker #(
        .MAX_BIN    (9999),
        .BLINK_HALF (5)
    ) dut (
        .clk_100ms (clk_100ms),
        .rst       (rst),
        .trk       (trk)
    );

    initial clk_100ms = 1'b0;
    always #5 clk_100ms = ~clk_100ms;

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk_100ms);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b0;
        trk.score     = 16'd0;
        trk.status    = 2'b00;
        trk.game_over = 1'b0;
        trk.clr_best  = 1'b0;
        #12;
        chk("rst_cur", trk.cur_bcd, 16'h0000);
        chk("rst_busy", {15'd0, trk.busy}, 16'd0);
        chk("rst_ovf", {15'd0, trk.overflow}, 16'd0);
        chk("rst_rec", {15'd0, trk.new_record}, 16'd0);
        chk("rst_blink", {15'd0, trk.blink}, 16'd0);
        chk("init_best", trk.best_bcd, 16'h0000);
        tick(1);
        rst = 1'b1;

        // Incremental path, one tick of latency
        trk.score = 16'd1; tick(1);
        chk("inc1", trk.cur_bcd, 16'h0001);
        trk.score = 16'd3; tick(1);
        chk("inc3", trk.cur_bcd, 16'h0003);
        trk.score = 16'd6; tick(1);
        chk("inc6", trk.cur_bcd, 16'h0006);
        chk("inc_busy", {15'd0, trk.busy}, 16'd0);

        // Jump to 99 then +1 carries across two digits
        trk.score = 16'd99; tick(1);
        chk("j99_busy", {15'd0, trk.busy}, 16'd1);
        tick(15);
        chk("j99_busy15", {15'd0, trk.busy}, 16'd1);
        chk("j99_hold", trk.cur_bcd, 16'h0006);
        tick(1);
        chk("j99_done", {15'd0, trk.busy}, 16'd0);
        chk("j99_cur", trk.cur_bcd, 16'h0099);
        trk.score = 16'd100; tick(1);
        chk("carry100", trk.cur_bcd, 16'h0100);

        // Jump to 1234, score moves to 1236 during the conversion
        trk.score = 16'd1234; tick(1);
        chk("j1234_busy", {15'd0, trk.busy}, 16'd1);
        tick(5);
        trk.score = 16'd1236;
        tick(10);
        chk("j1234_hold", trk.cur_bcd, 16'h0100);
        tick(1);
        chk("j1234_cur", trk.cur_bcd, 16'h1234);
        chk("j1234_busy0", {15'd0, trk.busy}, 16'd0);
        tick(1);
        chk("catch1236", trk.cur_bcd, 16'h1236);

        // A decrease also resyncs
        trk.score = 16'd1230; tick(1);
        chk("dec_busy", {15'd0, trk.busy}, 16'd1);
        tick(16);
        chk("dec_cur", trk.cur_bcd, 16'h1230);

        // Single-mode game ends at 30: first record
        rst = 1'b0; trk.score = 16'd0; #1;
        chk("rst2_cur", trk.cur_bcd, 16'h0000);
        tick(1); rst = 1'b1;
        trk.score = 16'd30; tick(17);
        chk("g30_cur", trk.cur_bcd, 16'h0030);
        trk.game_over = 1'b1; tick(2);
        chk("g30_rec", {15'd0, trk.new_record}, 16'd1);
        chk("g30_best", trk.best_bcd, 16'h0030);

        // Game ends at 42 beating 30; blink every 5 ticks, cur frozen
        rst = 1'b0; trk.game_over = 1'b0; trk.score = 16'd0; tick(1); rst = 1'b1;
        trk.score = 16'd42; tick(17);
        chk("g42_cur", trk.cur_bcd, 16'h0042);
        trk.game_over = 1'b1; tick(2);
        chk("g42_rec", {15'd0, trk.new_record}, 16'd1);
        chk("g42_bcd", trk.best_bcd, 16'h0042);
        chk("g42_bin", {2'b00, trk.best_bin}, 16'd42);
        chk("blink_e0", {15'd0, trk.blink}, 16'd0);
        trk.score = 16'd50;
        tick(4);
        chk("blink_e4", {15'd0, trk.blink}, 16'd0);
        tick(1);
        chk("blink_e5", {15'd0, trk.blink}, 16'd1);
        tick(4);
        chk("blink_e9", {15'd0, trk.blink}, 16'd1);
        tick(1);
        chk("blink_e10", {15'd0, trk.blink}, 16'd0);
        chk("over_frozen", trk.cur_bcd, 16'h0042);
        trk.status = 2'b10; #1;
        chk("dual_best", trk.best_bcd, 16'h0000);
        chk("dual_bin", {2'b00, trk.best_bin}, 16'd0);
        trk.status = 2'b01; #1;
        chk("single_back", trk.best_bcd, 16'h0042);

        // Game ends at 20 below best 42
        rst = 1'b0; trk.game_over = 1'b0; trk.score = 16'd0; #1;
        chk("rst_keeps_best", trk.best_bcd, 16'h0042);
        chk("rst_rec0", {15'd0, trk.new_record}, 16'd0);
        tick(1); rst = 1'b1;
        trk.score = 16'd20; tick(17);
        trk.game_over = 1'b1; tick(2);
        chk("g20_rec", {15'd0, trk.new_record}, 16'd0);
        chk("g20_best", trk.best_bcd, 16'h0042);
        tick(6);
        chk("g20_blink", {15'd0, trk.blink}, 16'd0);
        trk.clr_best = 1'b1; tick(1); trk.clr_best = 1'b0;
        chk("clr_bcd", trk.best_bcd, 16'h0000);
        chk("clr_bin", {2'b00, trk.best_bin}, 16'd0);

        // Delta-path saturation at 9999
        rst = 1'b0; trk.game_over = 1'b0; trk.score = 16'd0; tick(1); rst = 1'b1;
        trk.score = 16'd9998; tick(17);
        chk("s9998", trk.cur_bcd, 16'h9998);
        trk.score = 16'd9999; tick(1);
        chk("s9999", trk.cur_bcd, 16'h9999);
        chk("s9999_ovf", {15'd0, trk.overflow}, 16'd0);
        trk.score = 16'd10001; tick(1);
        chk("s10001", trk.cur_bcd, 16'h9999);
        chk("s10001_ovf", {15'd0, trk.overflow}, 16'd1);

        // Jump to 10000 in dual mode, then game over records 9999
        rst = 1'b0; trk.score = 16'd0; trk.status = 2'b10; tick(1); rst = 1'b1;
        chk("ovf_cleared", {15'd0, trk.overflow}, 16'd0);
        trk.score = 16'd10000; tick(1);
        chk("j10000_ovf", {15'd0, trk.overflow}, 16'd1);
        tick(16);
        chk("j10000_cur", trk.cur_bcd, 16'h9999);
        trk.game_over = 1'b1; tick(2);
        chk("j10000_best", trk.best_bcd, 16'h9999);
        chk("j10000_bin", {2'b00, trk.best_bin}, 16'd9999);
        chk("j10000_rec", {15'd0, trk.new_record}, 16'd1);
        chk("j10000_ovf2", {15'd0, trk.overflow}, 16'd1);
        trk.status = 2'b00; #1;
        chk("single_cleared", trk.best_bcd, 16'h0000);

        // Reset in the middle of a resync aborts it
        rst = 1'b0; trk.game_over = 1'b0; trk.score = 16'd0; tick(1); rst = 1'b1;
        trk.score = 16'd500; tick(5);
        rst = 1'b0; #1;
        chk("abort_busy", {15'd0, trk.busy}, 16'd0);
        chk("abort_cur", trk.cur_bcd, 16'h0000);
        trk.score = 16'd0; tick(1); rst = 1'b1;
        trk.score = 16'd2; tick(1);
        chk("abort_track", trk.cur_bcd, 16'h0002);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
